processing_tx: RTL and testbench

- Master-side transmitter. It drains the processed-word FIFO that the pixel processing stage writes into, and streams those words out on a valid/ready master bus.
- It parses the BMP file-size field from the header words as they pass through, so it knows the total beat count.
- It pulses mstr_data_cmplt once the last beat is accepted, which closes out the frame for the processing stage.

---
 rtl/processing_tx_pkg.sv | 35 +++
 rtl/processing_tx_if.sv | 23 ++
 rtl/processing_tx_skid_buf.sv | 67 ++++++
 rtl/processing_tx.sv | 173 +++++++++++++++++
 tb/tb_processing_tx.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processing_tx_pkg.sv
// processing_tx_pkg: FSM states, BMP size-field location and beat arithmetic
// shared by the processed-word transmitter.
package processing_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        DRAIN,
        DONE
    } tx_state_t;

    localparam int BMP_SIZE_OFS   = 2;
    localparam int BMP_SIZE_BYTES = 4;

    function automatic int unsigned hdr_beats(
        input int unsigned d_width,
        input int unsigned header_size = 14
    );
        return header_size * 32 / d_width;
    endfunction

    // ceil(size*8/d_width) == ceil(size/bytes_per_word): fits in 33 bits
    function automatic logic [32:0] beats_for_size(
        input logic [31:0] size,
        input int unsigned d_width
    );
        logic [32:0] s33;
        s33 = {1'b0, size};
        if (d_width == 64)
            return (s33 + 33'd7) >> 3;
        return (s33 + 33'd3) >> 2;
    endfunction

endpackage

// File: rtl/processing_tx_if.sv
// processing_tx_if: valid/ready master bus carrying processed words
// out of the transmitter.
interface processing_tx_if #(
    parameter int D_WIDTH = 32
);

    logic [D_WIDTH-1:0] mstr_data;
    logic               mstr_valid;
    logic               mstr_ready;

    modport master (
        output mstr_data,
        output mstr_valid,
        input  mstr_ready
    );

    modport slave (
        input  mstr_data,
        input  mstr_valid,
        output mstr_ready
    );

endinterface

// File: rtl/processing_tx_skid_buf.sv
// tx_skid_buf: 2-entry output buffer that absorbs the one-cycle FIFO
// read latency and grants pop credit only when a slot is guaranteed.
module tx_skid_buf #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pop_i,
    input  logic [D_WIDTH-1:0] in_data_i,
    input  logic               out_ready_i,
    output logic [D_WIDTH-1:0] out_data_o,
    output logic               out_valid_o,
    output logic               credit_o,
    output logic               rvalid_o,
    output logic               drained_o
);

    logic [D_WIDTH-1:0] mem_q [2];
    logic [D_WIDTH-1:0] mem_d [2];
    logic [1:0]         cnt_q, cnt_d;
    logic               head_q, head_d;
    logic               infl_q, infl_d;
    logic               enq, deq;

    always_comb begin
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        infl_d = pop_i;
        enq    = infl_q;
        deq    = (cnt_q != 2'd0) && out_ready_i;
        // tail slot is head+cnt; when full and dequeuing it reuses head
        if (enq)
            mem_d[head_q ^ cnt_q[0]] = in_data_i;
        if (deq)
            head_d = ~head_q;
        unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            cnt_q  <= 2'd0;
            head_q <= 1'b0;
            infl_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            infl_q <= infl_d;
        end
    end

    assign out_data_o  = mem_q[head_q];
    assign out_valid_o = cnt_q != 2'd0;
    assign rvalid_o    = infl_q;
    assign credit_o    = ({1'b0, cnt_q} + {2'b0, infl_q})
                         < (3'd2 + {2'b0, deq});
    assign drained_o   = !infl_q
                         && ((cnt_q == 2'd0)
                             || ((cnt_q == 2'd1) && out_ready_i));

endmodule

// File: rtl/processing_tx.sv
// processing_tx: drains the processed-word FIFO onto a valid/ready bus,
// parsing the BMP size field for the beat count. Option: TX_STALL_CNT_EN.
module processing_tx
    import processing_tx_pkg::*;
#(
    parameter int D_WIDTH     = 32,
    parameter int HEADER_SIZE = 14,
    parameter int SIZE_MIN    = 54
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] fifo_rdata,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    processing_tx_if.master    mstr,
    output logic               mstr_data_cmplt,
    output logic               mstr_err,
    output logic               tx_busy
`ifdef TX_STALL_CNT_EN
    ,
    output logic [15:0]        tx_stall_cnt
`endif
);

    localparam int          W    = D_WIDTH / 8;
    localparam int unsigned HB   = hdr_beats(D_WIDTH, HEADER_SIZE);
    localparam logic [31:0] HB32 = 32'(HB);
    localparam logic [32:0] HB33 = 33'(HB);

    tx_state_t   state_q, state_d;
    logic [31:0] pop_cnt_q, pop_cnt_d;
    logic [32:0] n_q, n_d;
    logic [31:0] size_q, size_d;
    logic [1:0]  rx_idx_q, rx_idx_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [32:0] limit;
    logic        pop, start;
    logic        credit, rvalid, drained, buf_valid;

    tx_skid_buf #(
        .D_WIDTH (D_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .pop_i       (pop),
        .in_data_i   (fifo_rdata),
        .out_ready_i (mstr.mstr_ready),
        .out_data_o  (mstr.mstr_data),
        .out_valid_o (buf_valid),
        .credit_o    (credit),
        .rvalid_o    (rvalid),
        .drained_o   (drained)
    );

    always_comb begin
        state_d   = state_q;
        pop_cnt_d = pop_cnt_q;
        n_d       = n_q;
        size_d    = size_q;
        rx_idx_d  = rx_idx_q;
        err_d     = err_q;
        busy_d    = busy_q;
        start     = 1'b0;
        // size is unknown until the header is through: cap at HDR_BEATS
        limit = (state_q == HDR) ? HB33 : n_q;
        pop   = !rst && !fifo_empty && credit
                && ((state_q == HDR) || (state_q == BODY))
                && ({1'b0, pop_cnt_q} < limit);
        if (pop)
            pop_cnt_d = pop_cnt_q + 32'd1;
        if (rvalid) begin
            for (int k = 0; k < BMP_SIZE_BYTES; k++) begin
                if (rx_idx_q == 2'((BMP_SIZE_OFS + k) / W))
                    size_d[8*k +: 8] =
                        fifo_rdata[8*((BMP_SIZE_OFS + k) % W) +: 8];
            end
            if (rx_idx_q != 2'd3)
                rx_idx_d = rx_idx_q + 2'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty)
                    start = 1'b1;
            end
            HDR: begin
                if (pop_cnt_d == HB32) begin
                    state_d = BODY;
                    if (size_q < 32'(SIZE_MIN)) begin
                        err_d = 1'b1;
                        n_d   = HB33;
                    end else begin
                        n_d = beats_for_size(size_q, D_WIDTH);
                    end
                end
            end
            BODY: begin
                if ({1'b0, pop_cnt_d} >= n_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!fifo_empty)
                    start = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d   = HDR;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            pop_cnt_d = 32'd0;
            n_d       = 33'd0;
            size_d    = 32'd0;
            rx_idx_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pop_cnt_q <= 32'd0;
            n_q       <= 33'd0;
            size_q    <= 32'd0;
            rx_idx_q  <= 2'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pop_cnt_q <= pop_cnt_d;
            n_q       <= n_d;
            size_q    <= size_d;
            rx_idx_q  <= rx_idx_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign fifo_rd         = pop;
    assign mstr.mstr_valid = buf_valid;
    assign mstr_data_cmplt = state_q == DONE;
    assign mstr_err        = err_q;
    assign tx_busy         = busy_q;

`ifdef TX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start)
            stall_cnt_d = 16'd0;
        else if (buf_valid && !mstr.mstr_ready
                 && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign tx_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_processing_tx.sv
// tb_processing_tx: directed frames through 32- and 64-bit transmitters
// with a queue-based FIFO model and hand-computed beat counts.
module tb_processing_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rdata32 = '0;
    logic [63:0] rdata64 = '0;
    logic        empty32 = 1'b1;
    logic        empty64 = 1'b1;
    logic        rd32, rd64;
    logic        cmplt32, cmplt64;
    logic        err32, err64;
    logic        busy32, busy64;
`ifdef TX_STALL_CNT_EN
    logic [15:0] stall32, stall64;
`endif

    always #5 clk = ~clk;

    processing_tx_if #(.D_WIDTH(32)) bus32();
    processing_tx_if #(.D_WIDTH(64)) bus64();

    processing_tx #(.D_WIDTH(32)) u_dut32 (
        .clk             (clk),
        .rst             (rst),
        .fifo_rdata      (rdata32),
        .fifo_empty      (empty32),
        .fifo_rd         (rd32),
        .mstr            (bus32),
        .mstr_data_cmplt (cmplt32),
        .mstr_err        (err32),
        .tx_busy         (busy32)
`ifdef TX_STALL_CNT_EN
        ,
        .tx_stall_cnt    (stall32)
`endif
    );

    processing_tx #(.D_WIDTH(64)) u_dut64 (
        .clk             (clk),
        .rst             (rst),
        .fifo_rdata      (rdata64),
        .fifo_empty      (empty64),
        .fifo_rd         (rd64),
        .mstr            (bus64),
        .mstr_data_cmplt (cmplt64),
        .mstr_err        (err64),
        .tx_busy         (busy64)
`ifdef TX_STALL_CNT_EN
        ,
        .tx_stall_cnt    (stall64)
`endif
    );

    logic [31:0] fq32[$];
    logic [63:0] fq64[$];
    int          pops32 = 0;
    int          pops64 = 0;
    int          pop_empty = 0;

    // FIFO model: one-cycle read latency, empty flag registered
    always @(posedge clk) begin
        if (rd32) begin
            if (fq32.size() == 0) pop_empty <= pop_empty + 1;
            else rdata32 <= fq32.pop_front();
            pops32 <= pops32 + 1;
        end
        if (rd64) begin
            if (fq64.size() == 0) pop_empty <= pop_empty + 1;
            else rdata64 <= fq64.pop_front();
            pops64 <= pops64 + 1;
        end
        empty32 <= fq32.size() == 0;
        empty64 <= fq64.size() == 0;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got[$];
    int          cmplt_at[$];
    int          cmplt_gap[$];
    int          first_c, last_c, stab_err;
    logic        err_first, busy_first, err_end, busy_end;
    bit          aborted;
    int          p0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load32(input logic [31:0] s, input int n,
                          input logic [7:0] tag);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            if (i == 0)      w = {s[15:0], 16'h4D42};
            else if (i == 1) w = {8'hA5, tag, s[31:16]};
            else             w = {tag, 8'h00, 16'(i)};
            fq32.push_back(w);
            exp_q.push_back({32'h0, w});
        end
    endtask

    task automatic load64(input logic [31:0] s, input int n,
                          input logic [7:0] tag);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            if (i == 0) w = {8'h00, tag, s, 16'h4D42};
            else        w = {tag, 24'h0, 32'(i)};
            fq64.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic run_frame(input bit w64, input bit tog,
                             input int frames, input int abort_at,
                             input int budget);
        bit          seen, rdy, v, cm, prev_stall;
        logic [63:0] d, prev_d;
        int          ph, last_cm;
        got.delete();
        cmplt_at.delete();
        cmplt_gap.delete();
        stab_err = 0; first_c = -1; last_c = -1; last_cm = -1;
        seen = 0; ph = 0; prev_stall = 0; prev_d = '0; aborted = 0;
        err_first = 1'bx; busy_first = 1'bx;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            v = w64 ? bus64.mstr_valid : bus32.mstr_valid;
            // 1-on/2-off ready, phase-locked to the first valid beat
            if (tog) begin
                if (!seen) begin
                    if (v) seen = 1;
                    ph = 0;
                end else begin
                    ph = (ph + 1) % 3;
                end
                rdy = !seen || (ph == 0);
            end else begin
                rdy = 1;
            end
            if (w64) bus64.mstr_ready = rdy;
            else     bus32.mstr_ready = rdy;
            #1;
            v  = w64 ? bus64.mstr_valid : bus32.mstr_valid;
            d  = w64 ? bus64.mstr_data : {32'h0, bus32.mstr_data};
            cm = w64 ? cmplt64 : cmplt32;
            if (prev_stall && (!v || d != prev_d)) stab_err++;
            prev_stall = v && !rdy;
            prev_d     = d;
            if (v && rdy) begin
                if (got.size() == 0) begin
                    first_c    = c;
                    err_first  = w64 ? err64 : err32;
                    busy_first = w64 ? busy64 : busy32;
                end
                got.push_back(d);
                last_c = c;
            end
            if (cm) begin
                cmplt_at.push_back(got.size());
                cmplt_gap.push_back(c - last_c);
                last_cm = c;
            end
            if (abort_at > 0 && got.size() == abort_at) begin
                aborted = 1;
                break;
            end
            if (cmplt_at.size() >= frames && c >= last_cm + 4) break;
        end
        err_end  = w64 ? err64 : err32;
        busy_end = w64 ? busy64 : busy32;
        if (w64) bus64.mstr_ready = 1;
        else     bus32.mstr_ready = 1;
    endtask

    task automatic frame_checks(input string t, input int n_exp,
                                input int frames);
        int mism;
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] !== exp_q[i]) mism++;
        check({t, "_beats"}, 64'(got.size()), 64'(n_exp));
        check({t, "_data"}, 64'(mism), 64'd0);
        check({t, "_npulse"}, 64'(cmplt_at.size()), 64'(frames));
        check({t, "_pulse_at"},
              64'(cmplt_at.size() > 0 ? cmplt_at[cmplt_at.size()-1] : -1),
              64'(n_exp));
        check({t, "_pulse_gap"},
              64'(cmplt_gap.size() > 0 ? cmplt_gap[cmplt_gap.size()-1] : -1),
              64'd1);
        check({t, "_busy_run"}, {63'h0, busy_first}, 64'd1);
        check({t, "_busy_end"}, {63'h0, busy_end}, 64'd0);
    endtask

    initial begin
        rst = 1;
        bus32.mstr_ready = 1;
        bus64.mstr_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_fifo_rd", {63'h0, rd32}, 64'd0);
        check("rst_valid", {63'h0, bus32.mstr_valid}, 64'd0);
        check("rst_data", {32'h0, bus32.mstr_data}, 64'd0);
        check("rst_cmplt", {63'h0, cmplt32}, 64'd0);
        check("rst_err", {63'h0, err32}, 64'd0);
        check("rst_busy", {63'h0, busy32}, 64'd0);
        @(negedge clk);
        rst = 0;

        // 70-byte frame, ready held high
        exp_q.delete();
        load32(32'h46, 18, 8'h11);
        p0 = pops32;
        run_frame(0, 0, 1, 0, 200);
        frame_checks("f70", 18, 1);
        check("f70_back2back", 64'(last_c - first_c), 64'd17);
        check("f70_pops", 64'(pops32 - p0), 64'd18);
        check("f70_err", {63'h0, err_end}, 64'd0);
`ifdef TX_STALL_CNT_EN
        check("f70_stall", {48'h0, stall32}, 64'd0);
`endif

        // same frame under 1-on/2-off backpressure
        exp_q.delete();
        load32(32'h46, 18, 8'h22);
        p0 = pops32;
        run_frame(0, 1, 1, 0, 300);
        frame_checks("tog", 18, 1);
        check("tog_stable", 64'(stab_err), 64'd0);
        check("tog_pops", 64'(pops32 - p0), 64'd18);
`ifdef TX_STALL_CNT_EN
        check("tog_stall", {48'h0, stall32}, 64'd34);
`endif

        // 64-bit bus, 80 bytes
        exp_q.delete();
        load64(32'h50, 10, 8'h33);
        p0 = pops64;
        run_frame(1, 0, 1, 0, 200);
        frame_checks("w64", 10, 1);
        check("w64_pops", 64'(pops64 - p0), 64'd10);
        check("w64_err", {63'h0, err_end}, 64'd0);

        // illegal size: header-only frame, sticky error
        exp_q.delete();
        load32(32'h10, 14, 8'h44);
        run_frame(0, 0, 1, 0, 200);
        frame_checks("ill", 14, 1);
        check("ill_err", {63'h0, err_end}, 64'd1);
        check("ill_fifo_left", 64'(fq32.size()), 64'd0);

        // next frame start clears the error
        exp_q.delete();
        load32(32'h46, 18, 8'h55);
        run_frame(0, 0, 1, 0, 200);
        frame_checks("clr", 18, 1);
        check("clr_err_run", {63'h0, err_first}, 64'd0);
        check("clr_err_end", {63'h0, err_end}, 64'd0);

        // back-to-back 70 then 60 bytes
        exp_q.delete();
        load32(32'h46, 18, 8'h66);
        load32(32'h3C, 15, 8'h67);
        run_frame(0, 0, 2, 0, 300);
        frame_checks("b2b", 33, 2);
        check("b2b_first_at",
              64'(cmplt_at.size() > 0 ? cmplt_at[0] : -1), 64'd18);

        // reset mid-frame
        exp_q.delete();
        load32(32'h46, 18, 8'h77);
        run_frame(0, 0, 1, 10, 200);
        check("abort_reached", {63'h0, aborted}, 64'd1);
        check("abort_no_pulse", 64'(cmplt_at.size()), 64'd0);
        rst = 1;
        @(negedge clk);
        #1;
        check("abort_fifo_rd", {63'h0, rd32}, 64'd0);
        check("abort_valid", {63'h0, bus32.mstr_valid}, 64'd0);
        check("abort_data", {32'h0, bus32.mstr_data}, 64'd0);
        check("abort_cmplt", {63'h0, cmplt32}, 64'd0);
        check("abort_busy", {63'h0, busy32}, 64'd0);
        fq32.delete();
        @(negedge clk);
        rst = 0;

        exp_q.delete();
        load32(32'h3C, 15, 8'h88);
        run_frame(0, 0, 1, 0, 200);
        frame_checks("post", 15, 1);

        check("pop_empty", 64'(pop_empty), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
